reorder_buffer: RTL and testbench

Circular in-order retirement buffer for the Tomasulo core. It sits between dispatch/execute and the architectural register file.
- Allocates a tag per dispatched instruction.
- Captures results from the ALU and LSB broadcast buses and supplies operand forwarding to the dispatcher.
- Retires one instruction per cycle, in order, to the register file (rob_en/reg_pos/dest/value) or to the LSB (store commit).
- On branch mispredict, flushes the pipeline and redirects fetch.

---
 rtl/reorder_buffer_pkg.sv | 27 ++
 rtl/reorder_buffer.sv | 160 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared widths, defaults and the per-entry record for the reorder buffer.
package reorder_buffer_pkg;

    localparam int ROB_SIZE_DEF = 16;
    localparam int TAG_W_DEF    = 4;
    localparam int DATA_W       = 32;
    localparam int REG_W        = 5;

    localparam logic [REG_W-1:0] REG_NULL = '0;

    typedef struct packed {
        logic              busy;
        logic              ready;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] value;
        logic              is_store;
        logic              is_branch;
        logic              pred_taken;
        logic              taken;
        logic [DATA_W-1:0] target;
    } rob_entry_t;

    function automatic logic is_mispredict(input rob_entry_t e);
        return e.is_branch && (e.taken != e.pred_taken);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: tag allocation, CDB capture, operand
// forwarding, single-issue commit and mispredict flush.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE = ROB_SIZE_DEF,
    parameter int TAG_W    = TAG_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,

    input  logic              dispatcher_en_in,
    input  logic [REG_W-1:0]  dispatcher_rd_in,
    input  logic              dispatcher_is_store_in,
    input  logic              dispatcher_is_branch_in,
    input  logic              dispatcher_pred_taken_in,
    output logic [TAG_W-1:0]  dispatcher_tag_out,
    output logic              rob_full_out,

    input  logic [TAG_W-1:0]  dispatcher_q1_tag_in,
    output logic              dispatcher_q1_ready_out,
    output logic [DATA_W-1:0] dispatcher_q1_value_out,
    input  logic [TAG_W-1:0]  dispatcher_q2_tag_in,
    output logic              dispatcher_q2_ready_out,
    output logic [DATA_W-1:0] dispatcher_q2_value_out,

    input  logic              alu_en_in,
    input  logic [TAG_W-1:0]  alu_tag_in,
    input  logic [DATA_W-1:0] alu_value_in,
    input  logic              alu_taken_in,
    input  logic [DATA_W-1:0] alu_target_in,

    input  logic              lsb_en_in,
    input  logic [TAG_W-1:0]  lsb_tag_in,
    input  logic [DATA_W-1:0] lsb_value_in,

    output logic              rob_en_out,
    output logic [REG_W-1:0]  rob_reg_pos_out,
    output logic [TAG_W-1:0]  rob_dest_out,
    output logic [DATA_W-1:0] rob_value_out,
    output logic              lsb_commit_en_out,
    output logic [TAG_W-1:0]  lsb_commit_tag_out,
    output logic              flush_out,
    output logic [DATA_W-1:0] flush_pc_out
);

    localparam logic [TAG_W:0] FULL_CNT = ROB_SIZE[TAG_W:0];

    rob_entry_t       ent [ROB_SIZE];
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count;

    rob_entry_t head_ent;
    logic       full;
    logic       can_retire;
    logic       do_flush;
    logic       do_disp;

    assign head_ent   = ent[head];
    assign full       = (count == FULL_CNT);
    assign can_retire = rdy_in && (count != '0) && head_ent.busy && head_ent.ready;
    assign do_flush   = can_retire && is_mispredict(head_ent);
    // A mispredict retiring this cycle wipes the tail, so any dispatch is dropped.
    assign do_disp    = rdy_in && dispatcher_en_in && !full && !do_flush;

    assign dispatcher_tag_out = tail;
    assign rob_full_out       = full;

    // Forwarding reads registered state only; the dispatcher snoops the CDB itself.
    assign dispatcher_q1_ready_out = ent[dispatcher_q1_tag_in].busy && ent[dispatcher_q1_tag_in].ready;
    assign dispatcher_q1_value_out = ent[dispatcher_q1_tag_in].value;
    assign dispatcher_q2_ready_out = ent[dispatcher_q2_tag_in].busy && ent[dispatcher_q2_tag_in].ready;
    assign dispatcher_q2_value_out = ent[dispatcher_q2_tag_in].value;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < ROB_SIZE; i++) ent[i] <= '0;
        end else if (rdy_in) begin
            if (do_disp) begin
                ent[tail] <= '{busy: 1'b1, ready: 1'b0, rd: dispatcher_rd_in, value: '0,
                               is_store: dispatcher_is_store_in,
                               is_branch: dispatcher_is_branch_in,
                               pred_taken: dispatcher_pred_taken_in,
                               taken: 1'b0, target: '0};
            end
            if (alu_en_in && ent[alu_tag_in].busy) begin
                ent[alu_tag_in].ready  <= 1'b1;
                ent[alu_tag_in].value  <= alu_value_in;
                ent[alu_tag_in].taken  <= alu_taken_in;
                ent[alu_tag_in].target <= alu_target_in;
            end
            if (lsb_en_in && ent[lsb_tag_in].busy) begin
                ent[lsb_tag_in].ready <= 1'b1;
                ent[lsb_tag_in].value <= lsb_value_in;
            end
            if (can_retire) ent[head].busy <= 1'b0;
            if (do_flush) begin
                for (int i = 0; i < ROB_SIZE; i++) begin
                    ent[i].busy  <= 1'b0;
                    ent[i].ready <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (do_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (can_retire) head <= head + TAG_W'(1);
            if (do_disp)    tail <= tail + TAG_W'(1);
            count <= count + {{TAG_W{1'b0}}, do_disp} - {{TAG_W{1'b0}}, can_retire};
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rob_en_out         <= 1'b0;
            rob_reg_pos_out    <= '0;
            rob_dest_out       <= '0;
            rob_value_out      <= '0;
            lsb_commit_en_out  <= 1'b0;
            lsb_commit_tag_out <= '0;
            flush_out          <= 1'b0;
            flush_pc_out       <= '0;
        end else begin
            rob_en_out        <= 1'b0;
            lsb_commit_en_out <= 1'b0;
            flush_out         <= 1'b0;
            if (can_retire) begin
                if (do_flush) begin
                    // jalr still writes its link register on the way out
                    flush_out       <= 1'b1;
                    flush_pc_out    <= head_ent.target;
                    rob_en_out      <= (head_ent.rd != REG_NULL);
                    rob_reg_pos_out <= head_ent.rd;
                    rob_dest_out    <= head;
                    rob_value_out   <= head_ent.value;
                end else if (head_ent.is_store) begin
                    lsb_commit_en_out  <= 1'b1;
                    lsb_commit_tag_out <= head;
                end else begin
                    rob_en_out      <= (head_ent.rd != REG_NULL);
                    rob_reg_pos_out <= head_ent.rd;
                    rob_dest_out    <= head;
                    rob_value_out   <= head_ent.value;
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        dispatcher_en_in = 1'b0;
    logic [4:0]  dispatcher_rd_in = '0;
    logic        dispatcher_is_store_in = 1'b0;
    logic        dispatcher_is_branch_in = 1'b0;
    logic        dispatcher_pred_taken_in = 1'b0;
    logic [3:0]  dispatcher_tag_out;
    logic        rob_full_out;
    logic [3:0]  dispatcher_q1_tag_in = '0;
    logic        dispatcher_q1_ready_out;
    logic [31:0] dispatcher_q1_value_out;
    logic [3:0]  dispatcher_q2_tag_in = '0;
    logic        dispatcher_q2_ready_out;
    logic [31:0] dispatcher_q2_value_out;
    logic        alu_en_in = 1'b0;
    logic [3:0]  alu_tag_in = '0;
    logic [31:0] alu_value_in = '0;
    logic        alu_taken_in = 1'b0;
    logic [31:0] alu_target_in = '0;
    logic        lsb_en_in = 1'b0;
    logic [3:0]  lsb_tag_in = '0;
    logic [31:0] lsb_value_in = '0;
    logic        rob_en_out;
    logic [4:0]  rob_reg_pos_out;
    logic [3:0]  rob_dest_out;
    logic [31:0] rob_value_out;
    logic        lsb_commit_en_out;
    logic [3:0]  lsb_commit_tag_out;
    logic        flush_out;
    logic [31:0] flush_pc_out;

    always #5 clk_in = ~clk_in;

    reorder_buffer #(.ROB_SIZE(16), .TAG_W(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .dispatcher_en_in(dispatcher_en_in), .dispatcher_rd_in(dispatcher_rd_in),
        .dispatcher_is_store_in(dispatcher_is_store_in),
        .dispatcher_is_branch_in(dispatcher_is_branch_in),
        .dispatcher_pred_taken_in(dispatcher_pred_taken_in),
        .dispatcher_tag_out(dispatcher_tag_out), .rob_full_out(rob_full_out),
        .dispatcher_q1_tag_in(dispatcher_q1_tag_in),
        .dispatcher_q1_ready_out(dispatcher_q1_ready_out),
        .dispatcher_q1_value_out(dispatcher_q1_value_out),
        .dispatcher_q2_tag_in(dispatcher_q2_tag_in),
        .dispatcher_q2_ready_out(dispatcher_q2_ready_out),
        .dispatcher_q2_value_out(dispatcher_q2_value_out),
        .alu_en_in(alu_en_in), .alu_tag_in(alu_tag_in), .alu_value_in(alu_value_in),
        .alu_taken_in(alu_taken_in), .alu_target_in(alu_target_in),
        .lsb_en_in(lsb_en_in), .lsb_tag_in(lsb_tag_in), .lsb_value_in(lsb_value_in),
        .rob_en_out(rob_en_out), .rob_reg_pos_out(rob_reg_pos_out),
        .rob_dest_out(rob_dest_out), .rob_value_out(rob_value_out),
        .lsb_commit_en_out(lsb_commit_en_out), .lsb_commit_tag_out(lsb_commit_tag_out),
        .flush_out(flush_out), .flush_pc_out(flush_pc_out)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: in-flight instructions in program order.
    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  rd;
        bit          st, br, pred, rdy, taken;
        logic [31:0] val, tgt;
    } ment_t;

    ment_t       mq[$];
    int          m_tail = 0;
    bit          e_rob_en, e_lsb_en, e_flush;
    logic [4:0]  e_reg;
    logic [3:0]  e_dest, e_lsb_tag;
    logic [31:0] e_val, e_pc;

    function automatic void model_clear();
        mq.delete();
        m_tail   = 0;
        e_rob_en = 0;
        e_lsb_en = 0;
        e_flush  = 0;
    endfunction

    function automatic bit model_query(input logic [3:0] t, output logic [31:0] v);
        v = '0;
        foreach (mq[i]) if (mq[i].tag == t && mq[i].rdy) begin
            v = mq[i].val;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic idle_inputs();
        dispatcher_en_in = 0; dispatcher_rd_in = '0; dispatcher_is_store_in = 0;
        dispatcher_is_branch_in = 0; dispatcher_pred_taken_in = 0;
        alu_en_in = 0; alu_taken_in = 0; alu_tag_in = '0; alu_value_in = '0; alu_target_in = '0;
        lsb_en_in = 0; lsb_tag_in = '0; lsb_value_in = '0;
    endtask

    task automatic set_disp(input bit en, input logic [4:0] rd, input bit st, input bit br, input bit pred);
        dispatcher_en_in = en; dispatcher_rd_in = rd; dispatcher_is_store_in = st;
        dispatcher_is_branch_in = br; dispatcher_pred_taken_in = pred;
    endtask

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic tick();
        ment_t h, ne;
        bit    ret, mis, acc;
        @(posedge clk_in);
        e_rob_en = 0; e_lsb_en = 0; e_flush = 0;
        if (rdy_in) begin
            ret = (mq.size() != 0) && mq[0].rdy;
            mis = 0;
            if (ret) begin
                h   = mq[0];
                mis = h.br && (h.taken != h.pred);
                if (mis) begin
                    e_flush = 1; e_pc = h.tgt;
                    e_rob_en = (h.rd != 0); e_reg = h.rd; e_dest = h.tag; e_val = h.val;
                end else if (h.st) begin
                    e_lsb_en = 1; e_lsb_tag = h.tag;
                end else begin
                    e_rob_en = (h.rd != 0); e_reg = h.rd; e_dest = h.tag; e_val = h.val;
                end
            end
            acc = dispatcher_en_in && (mq.size() < 16) && !mis;
            foreach (mq[i]) begin
                if (alu_en_in && mq[i].tag == alu_tag_in) begin
                    mq[i].rdy = 1; mq[i].val = alu_value_in;
                    mq[i].taken = alu_taken_in; mq[i].tgt = alu_target_in;
                end
                if (lsb_en_in && mq[i].tag == lsb_tag_in) begin
                    mq[i].rdy = 1; mq[i].val = lsb_value_in;
                end
            end
            if (mis) begin
                mq.delete();
                m_tail = 0;
            end else if (ret) begin
                void'(mq.pop_front());
            end
            if (acc) begin
                ne.tag = m_tail[3:0]; ne.rd = dispatcher_rd_in; ne.st = dispatcher_is_store_in;
                ne.br = dispatcher_is_branch_in; ne.pred = dispatcher_pred_taken_in;
                ne.rdy = 0; ne.taken = 0; ne.val = '0; ne.tgt = '0;
                mq.push_back(ne);
                m_tail = (m_tail + 1) % 16;
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rdy_in = 1;
        rst_in = 1;
        repeat (2) @(negedge clk_in);
        rst_in = 0;
        model_clear();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (rob_en_out !== 1'b0) begin n_err++; $display("FAIL reset_rob_en: got %b want 0", rob_en_out); end
        n_cmp++; if (lsb_commit_en_out !== 1'b0) begin n_err++; $display("FAIL reset_lsb_commit: got %b want 0", lsb_commit_en_out); end
        n_cmp++; if (flush_out !== 1'b0 || flush_pc_out !== 32'h0) begin n_err++; $display("FAIL reset_flush: got %b/%h want 0/0", flush_out, flush_pc_out); end
        n_cmp++; if (rob_full_out !== 1'b0 || dispatcher_tag_out !== 4'd0) begin n_err++; $display("FAIL reset_ptrs: got full=%b tag=%0d want 0/0", rob_full_out, dispatcher_tag_out); end
        n_cmp++; if (rob_value_out !== 32'h0 || rob_reg_pos_out !== 5'd0) begin n_err++; $display("FAIL reset_data: got %h/%0d want 0/0", rob_value_out, rob_reg_pos_out); end
    endtask

    task automatic test_basic_commit();
        apply_reset();
        set_disp(1, 5'd5, 0, 0, 0); tick();
        idle_inputs();
        alu_en_in = 1; alu_tag_in = 4'd0; alu_value_in = 32'h1234; tick();
        idle_inputs();
        n_cmp++; if (rob_en_out !== 1'b0) begin n_err++; $display("FAIL basic_early: got %b want 0", rob_en_out); end
        tick();
        n_cmp++; if (rob_en_out !== 1'b1 || rob_reg_pos_out !== 5'd5 || rob_dest_out !== 4'd0 || rob_value_out !== 32'h1234)
            begin n_err++; $display("FAIL basic_commit: got en=%b rd=%0d tag=%0d val=%h want 1/5/0/1234", rob_en_out, rob_reg_pos_out, rob_dest_out, rob_value_out); end
        tick();
        n_cmp++; if (rob_en_out !== 1'b0 || dispatcher_tag_out !== 4'd1) begin n_err++; $display("FAIL basic_after: got en=%b tag=%0d want 0/1", rob_en_out, dispatcher_tag_out); end
    endtask

    task automatic test_full_wrap();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            set_disp(1, 5'(i + 1), 0, 0, 0); tick();
        end
        n_cmp++; if (rob_full_out !== 1'b1 || dispatcher_tag_out !== 4'd0) begin n_err++; $display("FAIL full_set: got full=%b tag=%0d want 1/0", rob_full_out, dispatcher_tag_out); end
        set_disp(1, 5'd20, 0, 0, 0); tick();
        n_cmp++; if (rob_full_out !== 1'b1 || dispatcher_tag_out !== 4'd0) begin n_err++; $display("FAIL full_ignore: got full=%b tag=%0d want 1/0", rob_full_out, dispatcher_tag_out); end
        idle_inputs();
        alu_en_in = 1; alu_tag_in = 4'd0; alu_value_in = 32'h55; tick();
        idle_inputs(); tick();
        n_cmp++; if (rob_en_out !== 1'b1 || rob_dest_out !== 4'd0 || rob_reg_pos_out !== 5'd1 || rob_value_out !== 32'h55)
            begin n_err++; $display("FAIL full_retire: got en=%b tag=%0d rd=%0d val=%h want 1/0/1/55", rob_en_out, rob_dest_out, rob_reg_pos_out, rob_value_out); end
        n_cmp++; if (rob_full_out !== 1'b0 || dispatcher_tag_out !== 4'd0) begin n_err++; $display("FAIL full_drop: got full=%b tag=%0d want 0/0", rob_full_out, dispatcher_tag_out); end
        set_disp(1, 5'd21, 0, 0, 0); tick();
        n_cmp++; if (rob_full_out !== 1'b1 || dispatcher_tag_out !== 4'd1) begin n_err++; $display("FAIL full_wrap: got full=%b tag=%0d want 1/1", rob_full_out, dispatcher_tag_out); end
        idle_inputs();
        alu_en_in = 1; alu_tag_in = 4'd1; alu_value_in = 32'h66; tick();
        idle_inputs();
        set_disp(1, 5'd22, 0, 0, 0); tick();
        idle_inputs();
        n_cmp++; if (rob_en_out !== 1'b1 || rob_dest_out !== 4'd1 || rob_full_out !== 1'b0 || dispatcher_tag_out !== 4'd1)
            begin n_err++; $display("FAIL full_retire_disp: got en=%b tag=%0d full=%b tail=%0d want 1/1/0/1", rob_en_out, rob_dest_out, rob_full_out, dispatcher_tag_out); end
    endtask

    task automatic test_in_order();
        apply_reset();
        set_disp(1, 5'd1, 0, 0, 0); tick();
        set_disp(1, 5'd2, 0, 0, 0); tick();
        idle_inputs();
        alu_en_in = 1; alu_tag_in = 4'd1; alu_value_in = 32'hAAAA; tick();
        idle_inputs(); tick();
        n_cmp++; if (rob_en_out !== 1'b0) begin n_err++; $display("FAIL order_wait: got %b want 0", rob_en_out); end
        alu_en_in = 1; alu_tag_in = 4'd0; alu_value_in = 32'hBBBB; tick();
        idle_inputs(); tick();
        n_cmp++; if (rob_en_out !== 1'b1 || rob_dest_out !== 4'd0 || rob_value_out !== 32'hBBBB) begin n_err++; $display("FAIL order_first: got en=%b tag=%0d val=%h want 1/0/bbbb", rob_en_out, rob_dest_out, rob_value_out); end
        tick();
        n_cmp++; if (rob_en_out !== 1'b1 || rob_dest_out !== 4'd1 || rob_value_out !== 32'hAAAA) begin n_err++; $display("FAIL order_second: got en=%b tag=%0d val=%h want 1/1/aaaa", rob_en_out, rob_dest_out, rob_value_out); end
    endtask

    task automatic test_flush();
        apply_reset();
        set_disp(1, 5'd1, 0, 0, 0); tick();
        set_disp(1, 5'd2, 0, 0, 0); tick();
        set_disp(1, 5'd0, 0, 1, 0); tick();
        set_disp(1, 5'd4, 0, 0, 0); tick();
        set_disp(1, 5'd5, 0, 0, 0); tick();
        idle_inputs();
        alu_en_in = 1; alu_tag_in = 4'd0; alu_value_in = 32'h11;
        lsb_en_in = 1; lsb_tag_in = 4'd1; lsb_value_in = 32'h22;
        tick();
        idle_inputs();
        dispatcher_q1_tag_in = 4'd0; dispatcher_q2_tag_in = 4'd1; #1;
        n_cmp++; if (dispatcher_q1_ready_out !== 1'b1 || dispatcher_q1_value_out !== 32'h11) begin n_err++; $display("FAIL flush_q_alu: got %b/%h want 1/11", dispatcher_q1_ready_out, dispatcher_q1_value_out); end
        n_cmp++; if (dispatcher_q2_ready_out !== 1'b1 || dispatcher_q2_value_out !== 32'h22) begin n_err++; $display("FAIL flush_q_lsb: got %b/%h want 1/22", dispatcher_q2_ready_out, dispatcher_q2_value_out); end
        alu_en_in = 1; alu_tag_in = 4'd2; alu_value_in = 32'h0; alu_taken_in = 1; alu_target_in = 32'h100; tick();
        idle_inputs();
        n_cmp++; if (rob_en_out !== 1'b1 || rob_dest_out !== 4'd0) begin n_err++; $display("FAIL flush_pre0: got en=%b tag=%0d want 1/0", rob_en_out, rob_dest_out); end
        tick();
        n_cmp++; if (rob_en_out !== 1'b1 || rob_dest_out !== 4'd1 || rob_value_out !== 32'h22) begin n_err++; $display("FAIL flush_pre1: got en=%b tag=%0d val=%h want 1/1/22", rob_en_out, rob_dest_out, rob_value_out); end
        set_disp(1, 5'd9, 0, 0, 0); tick();
        idle_inputs();
        dispatcher_q1_tag_in = 4'd3; #1;
        n_cmp++; if (flush_out !== 1'b1 || flush_pc_out !== 32'h100 || rob_en_out !== 1'b0) begin n_err++; $display("FAIL flush_fire: got flush=%b pc=%h en=%b want 1/100/0", flush_out, flush_pc_out, rob_en_out); end
        n_cmp++; if (dispatcher_tag_out !== 4'd0 || rob_full_out !== 1'b0 || dispatcher_q1_ready_out !== 1'b0) begin n_err++; $display("FAIL flush_state: got tail=%0d full=%b q=%b want 0/0/0", dispatcher_tag_out, rob_full_out, dispatcher_q1_ready_out); end
        tick();
        n_cmp++; if (flush_out !== 1'b0 || dispatcher_tag_out !== 4'd0) begin n_err++; $display("FAIL flush_pulse: got flush=%b tail=%0d want 0/0", flush_out, dispatcher_tag_out); end
    endtask

    task automatic test_store_fwd();
        apply_reset();
        set_disp(1, 5'd0, 1, 0, 0); tick();
        set_disp(1, 5'd7, 0, 0, 0); tick();
        idle_inputs();
        dispatcher_q1_tag_in = 4'd1; #1;
        n_cmp++; if (dispatcher_q1_ready_out !== 1'b0) begin n_err++; $display("FAIL fwd_pending: got %b want 0", dispatcher_q1_ready_out); end
        lsb_en_in = 1; lsb_tag_in = 4'd0; lsb_value_in = 32'h0;
        alu_en_in = 1; alu_tag_in = 4'd1; alu_value_in = 32'hCAFE;
        tick();
        idle_inputs();
        dispatcher_q1_tag_in = 4'd1; dispatcher_q2_tag_in = 4'd0; #1;
        n_cmp++; if (dispatcher_q1_ready_out !== 1'b1 || dispatcher_q1_value_out !== 32'hCAFE || dispatcher_q2_ready_out !== 1'b1)
            begin n_err++; $display("FAIL fwd_ready: got %b/%h/%b want 1/cafe/1", dispatcher_q1_ready_out, dispatcher_q1_value_out, dispatcher_q2_ready_out); end
        tick();
        n_cmp++; if (lsb_commit_en_out !== 1'b1 || lsb_commit_tag_out !== 4'd0 || rob_en_out !== 1'b0)
            begin n_err++; $display("FAIL store_commit: got lsb=%b tag=%0d rob=%b want 1/0/0", lsb_commit_en_out, lsb_commit_tag_out, rob_en_out); end
        tick();
        n_cmp++; if (rob_en_out !== 1'b1 || rob_reg_pos_out !== 5'd7 || rob_dest_out !== 4'd1 || lsb_commit_en_out !== 1'b0)
            begin n_err++; $display("FAIL store_next: got en=%b rd=%0d tag=%0d lsb=%b want 1/7/1/0", rob_en_out, rob_reg_pos_out, rob_dest_out, lsb_commit_en_out); end
    endtask

    task automatic test_rdy_hold();
        apply_reset();
        rdy_in = 0; set_disp(1, 5'd3, 0, 0, 0); tick();
        n_cmp++; if (dispatcher_tag_out !== 4'd0) begin n_err++; $display("FAIL rdy_disp: got %0d want 0", dispatcher_tag_out); end
        rdy_in = 1; tick();
        idle_inputs();
        rdy_in = 0; alu_en_in = 1; alu_tag_in = 4'd0; alu_value_in = 32'h77; tick();
        idle_inputs(); rdy_in = 1;
        dispatcher_q1_tag_in = 4'd0; #1;
        n_cmp++; if (dispatcher_q1_ready_out !== 1'b0 || dispatcher_tag_out !== 4'd1) begin n_err++; $display("FAIL rdy_wb: got q=%b tail=%0d want 0/1", dispatcher_q1_ready_out, dispatcher_tag_out); end
        alu_en_in = 1; alu_tag_in = 4'd0; alu_value_in = 32'h77; tick();
        idle_inputs(); rdy_in = 0; tick();
        n_cmp++; if (rob_en_out !== 1'b0) begin n_err++; $display("FAIL rdy_commit_hold: got %b want 0", rob_en_out); end
        rdy_in = 1; tick();
        n_cmp++; if (rob_en_out !== 1'b1 || rob_dest_out !== 4'd0 || rob_value_out !== 32'h77) begin n_err++; $display("FAIL rdy_commit: got en=%b tag=%0d val=%h want 1/0/77", rob_en_out, rob_dest_out, rob_value_out); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            set_disp(1, 5'(i + 10), 0, 0, 0); tick();
        end
        idle_inputs();
        alu_en_in = 1; alu_tag_in = 4'd0; alu_value_in = 32'h9; tick();
        idle_inputs(); tick();
        n_cmp++; if (rob_en_out !== 1'b1) begin n_err++; $display("FAIL midrst_pre: got %b want 1", rob_en_out); end
        rst_in = 1; #1;
        n_cmp++; if (rob_en_out !== 1'b0 || rob_value_out !== 32'h0 || dispatcher_tag_out !== 4'd0 || rob_full_out !== 1'b0)
            begin n_err++; $display("FAIL midrst_clear: got en=%b val=%h tail=%0d full=%b want 0/0/0/0", rob_en_out, rob_value_out, dispatcher_tag_out, rob_full_out); end
        @(negedge clk_in);
        rst_in = 0;
        model_clear();
        set_disp(1, 5'd1, 0, 0, 0); tick();
        idle_inputs();
        dispatcher_q1_tag_in = 4'd1; #1;
        n_cmp++; if (dispatcher_tag_out !== 4'd1 || dispatcher_q1_ready_out !== 1'b0) begin n_err++; $display("FAIL midrst_disp: got tail=%0d q=%b want 1/0", dispatcher_tag_out, dispatcher_q1_ready_out); end
    endtask

    task automatic test_random();
        int          cand[$];
        int          ai;
        logic [31:0] v1, v2;
        bit          r1, r2;
        apply_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            idle_inputs();
            rdy_in = ($urandom_range(0, 9) != 0);
            set_disp($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), 0, 0, 1'($urandom));
            if ($urandom_range(0, 9) < 2) dispatcher_is_store_in = 1;
            else if ($urandom_range(0, 9) < 3) dispatcher_is_branch_in = 1;
            ai = -1;
            cand.delete();
            foreach (mq[i]) if (!mq[i].rdy && !mq[i].st) cand.push_back(i);
            if (cand.size() != 0 && $urandom_range(0, 9) < 6) begin
                ai = cand[$urandom_range(0, cand.size() - 1)];
                alu_en_in = 1; alu_tag_in = mq[ai].tag; alu_value_in = $urandom;
                alu_taken_in = mq[ai].pred ^ ($urandom_range(0, 3) == 0);
                alu_target_in = $urandom;
            end
            cand.delete();
            foreach (mq[i]) if (!mq[i].rdy && i != ai) cand.push_back(i);
            if (cand.size() != 0 && $urandom_range(0, 9) < 5) begin
                lsb_en_in = 1; lsb_tag_in = mq[cand[$urandom_range(0, cand.size() - 1)]].tag;
                lsb_value_in = $urandom;
            end
            tick();
            n_cmp++; if (rob_en_out !== e_rob_en || (e_rob_en && (rob_reg_pos_out !== e_reg || rob_dest_out !== e_dest || rob_value_out !== e_val)))
                begin n_err++; $display("FAIL rnd_rob c%0d: got %b/%0d/%0d/%h want %b/%0d/%0d/%h", cyc, rob_en_out, rob_reg_pos_out, rob_dest_out, rob_value_out, e_rob_en, e_reg, e_dest, e_val); end
            n_cmp++; if (lsb_commit_en_out !== e_lsb_en || (e_lsb_en && lsb_commit_tag_out !== e_lsb_tag))
                begin n_err++; $display("FAIL rnd_lsb c%0d: got %b/%0d want %b/%0d", cyc, lsb_commit_en_out, lsb_commit_tag_out, e_lsb_en, e_lsb_tag); end
            n_cmp++; if (flush_out !== e_flush || (e_flush && flush_pc_out !== e_pc))
                begin n_err++; $display("FAIL rnd_flush c%0d: got %b/%h want %b/%h", cyc, flush_out, flush_pc_out, e_flush, e_pc); end
            n_cmp++; if (dispatcher_tag_out !== m_tail[3:0] || rob_full_out !== (mq.size() == 16))
                begin n_err++; $display("FAIL rnd_ptr c%0d: got tail=%0d full=%b want %0d/%b", cyc, dispatcher_tag_out, rob_full_out, m_tail, mq.size() == 16); end
            dispatcher_q1_tag_in = 4'($urandom); dispatcher_q2_tag_in = 4'($urandom); #1;
            r1 = model_query(dispatcher_q1_tag_in, v1);
            r2 = model_query(dispatcher_q2_tag_in, v2);
            n_cmp++; if (dispatcher_q1_ready_out !== r1 || (r1 && dispatcher_q1_value_out !== v1))
                begin n_err++; $display("FAIL rnd_q1 c%0d: got %b/%h want %b/%h", cyc, dispatcher_q1_ready_out, dispatcher_q1_value_out, r1, v1); end
            n_cmp++; if (dispatcher_q2_ready_out !== r2 || (r2 && dispatcher_q2_value_out !== v2))
                begin n_err++; $display("FAIL rnd_q2 c%0d: got %b/%h want %b/%h", cyc, dispatcher_q2_ready_out, dispatcher_q2_value_out, r2, v2); end
        end
        rdy_in = 1;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic_commit();
        test_full_wrap();
        test_in_order();
        test_flush();
        test_store_fwd();
        test_rdy_hold();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
